usb_fs_tx_serializer: RTL and testbench
=======================================

USB_FS_TX_SERIALIZER -- requirements
Module: usb_fs_tx_serializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, meaning clk_48mhz cycles per USB full-speed bit time (12 Mb/s).
REQ-002 SHALL have port clk_48mhz  input  1  sole clock, 48 MHz; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tx_start  input  1  single-cycle request to begin a packet; sampled only when tx_busy=0.
REQ-005 SHALL have port tx_pid  input  4  PID nibble, captured on accepted tx_start.
REQ-006 SHALL have port tx_data_avail  input  1  upstream has a payload byte ready on tx_data.
REQ-007 SHALL have port tx_data  input  8  payload byte; CRC bytes are supplied by upstream as ordinary payload.
REQ-008 SHALL have port tx_data_get  output  1  one-cycle pulse: tx_data consumed this cycle.
REQ-009 SHALL have port tx_busy  output  1  high from the cycle after an accepted tx_start until the end of EOP.
REQ-010 SHALL have ports usb_p_tx, usb_n_tx, usb_tx_en  output  1 each  line drive to the PHY tristate buffers.

Function
REQ-011 SHALL implement states IDLE, SYNC, PID, DATA, EOP_SE0, EOP_J.
REQ-012 IDLE: usb_tx_en=0, usb_p_tx=1, usb_n_tx=0 (J), tx_busy=0; tx_start=1 -> SYNC, bit divider cleared, NRZI level = J, ones counter = 0.
REQ-013 Bit divider SHALL count 0..BIT_CYCLES-1 while busy; each line state held exactly BIT_CYCLES cycles; bit boundary at count BIT_CYCLES-1.
REQ-014 usb_tx_en SHALL rise on the first clock edge after tx_start is accepted, with the first SYNC bit already on the line.
REQ-015 SYNC SHALL transmit 0x80 LSB-first (seven 0, then one 1) -> PID.
REQ-016 PID SHALL transmit {~tx_pid, tx_pid} LSB-first -> DATA handling at its last bit boundary.
REQ-017 At each byte-end boundary (PID or DATA): tx_data_avail=1 -> load tx_data, pulse tx_data_get that cycle, stay/enter DATA; tx_data_avail=0 -> EOP_SE0.
REQ-018 NRZI: data bit 0 toggles the line (J<->K), bit 1 holds; J = p1/n0, K = p0/n1.
REQ-019 Bit stuffing: ones counter spans SYNC, PID, DATA; after six consecutive 1s a stuffed 0 (one full bit time) SHALL be inserted and counter cleared; any 0 clears counter.
REQ-020 A stuff bit due after the final payload bit SHALL be sent before EOP; tx_data_get for a following byte SHALL be delayed by the stuff bit.
REQ-021 EOP_SE0: p=0, n=0 for two bit times -> EOP_J: J for one bit time, no stuffing/NRZI.
REQ-022 End of EOP_J: usb_tx_en=0, tx_busy=0 on the same edge -> IDLE; new tx_start accepted from the following cycle.
REQ-023 tx_start while tx_busy=1 SHALL be ignored without side effects.
REQ-024 Zero-length packet (tx_data_avail=0 at PID end) SHALL go directly to EOP; tx_data_get never pulses.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset=1 SHALL on the next edge force IDLE: usb_tx_en=0, usb_p_tx=1, usb_n_tx=0, tx_busy=0, tx_data_get=0, divider and ones counter 0, regardless of state (including mid-packet; no EOP sent).
REQ-027 reset SHALL take precedence over tx_start in the same cycle.

Verification
REQ-028 Reset: assert reset 2 cycles -> usb_p_tx=1, usb_n_tx=0, usb_tx_en=0, tx_busy=0, tx_data_get=0.
REQ-029 ACK: tx_pid=4'h2, tx_data_avail=0 -> PID byte 0xD2, no stuffing, usb_tx_en high exactly 76 cycles (16 bits + 3 EOP), first bit K, last two bits before EOP K,K, then SE0 8 cycles, J 4 cycles.
REQ-030 Stuffing: tx_pid=4'h3 (0xC3), payload 0xFF,0xFF -> 3 stuff bits (after byte1 bit3, byte2 bit1, byte2 bit7), usb_tx_en high 152 cycles, tx_data_get pulses exactly twice.
REQ-031 Zero-length DATA1: tx_pid=4'hB (0x4B), tx_data_avail=0 -> 76 enabled cycles, no tx_data_get.
REQ-032 Reset mid-DATA: assert reset during byte 2 -> next edge usb_tx_en=0, J, tx_busy=0; subsequent tx_start yields a correct packet.
REQ-033 tx_start pulsed during SYNC and during EOP_J -> ignored; packet bit-exact to single-start reference.

Source files
------------

// File: rtl/usb_fs_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : usb_fs_tx_serializer
// Brief    : USB full-speed packet transmitter: SYNC, PID, payload, EOP with
//            NRZI encoding and bit stuffing, driving the PHY line buffers.
// Revision : 1.0 - initial release
// ============================================================================
module usb_fs_tx_serializer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_data_avail,
    input  logic [7:0] tx_data,
    output logic       tx_data_get,
    output logic       tx_busy,
    output logic       usb_p_tx,
    output logic       usb_n_tx,
    output logic       usb_tx_en
);

    localparam int                 c_DIV_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BIT_CYCLES - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [7:0]         c_SYNC     = 8'h80;

    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_SYNC    = 3'd1;
    localparam logic [2:0] c_S_PID     = 3'd2;
    localparam logic [2:0] c_S_DATA    = 3'd3;
    localparam logic [2:0] c_S_EOP_SE0 = 3'd4;
    localparam logic [2:0] c_S_EOP_J   = 3'd5;

    logic [2:0]         r_state;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [2:0]         r_ones;
    logic               r_level;
    logic [3:0]         r_pid;
    logic               r_p;
    logic               r_n;
    logic               r_en;
    logic               r_busy;
    logic               r_get;

    logic [2:0]         w_state_next;
    logic [c_DIV_W-1:0] w_div_next;
    logic [2:0]         w_idx_next;
    logic [7:0]         w_shift_next;
    logic [2:0]         w_ones_next;
    logic               w_level_next;
    logic [3:0]         w_pid_next;
    logic               w_get_next;
    logic               w_place;
    logic               w_bit;
    logic               w_boundary;
    logic               w_p_next;
    logic               w_n_next;
    logic               w_en_next;
    logic               w_busy_next;

    assign w_boundary = (r_div == c_DIV_LAST);

    // State register: every output is taken from a flop.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_div   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_ones  <= 3'd0;
            r_level <= 1'b1;
            r_pid   <= 4'h0;
            r_p     <= 1'b1;
            r_n     <= 1'b0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_get   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_ones  <= w_ones_next;
            r_level <= w_level_next;
            r_pid   <= w_pid_next;
            r_p     <= w_p_next;
            r_n     <= w_n_next;
            r_en    <= w_en_next;
            r_busy  <= w_busy_next;
            r_get   <= w_get_next;
        end
    end

    // Next state: at each bit boundary choose either a stuff bit, the next
    // bit of the current byte, or the byte-end transition.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_ones_next  = r_ones;
        w_level_next = r_level;
        w_pid_next   = r_pid;
        w_get_next   = 1'b0;
        w_place      = 1'b0;
        w_bit        = 1'b0;

        if (r_state != c_S_IDLE) begin
            w_div_next = w_boundary ? '0 : (r_div + c_DIV_ONE);
        end

        case (r_state)
            c_S_IDLE: begin
                if (tx_start) begin
                    w_state_next = c_S_SYNC;
                    w_div_next   = '0;
                    w_idx_next   = 3'd0;
                    w_shift_next = c_SYNC;
                    w_pid_next   = tx_pid;
                    w_level_next = 1'b1;
                    w_ones_next  = 3'd0;
                    w_place      = 1'b1;
                    w_bit        = c_SYNC[0];
                end
            end
            c_S_SYNC, c_S_PID, c_S_DATA: begin
                if (w_boundary) begin
                    if (r_ones == 3'd6) begin
                        w_place = 1'b1;
                        w_bit   = 1'b0;
                    end else if (r_idx != 3'd7) begin
                        w_idx_next = r_idx + 3'd1;
                        w_place    = 1'b1;
                        w_bit      = r_shift[r_idx + 3'd1];
                    end else if (r_state == c_S_SYNC) begin
                        w_state_next = c_S_PID;
                        w_idx_next   = 3'd0;
                        w_shift_next = {~r_pid, r_pid};
                        w_place      = 1'b1;
                        w_bit        = r_pid[0];
                    end else if (tx_data_avail) begin
                        w_state_next = c_S_DATA;
                        w_idx_next   = 3'd0;
                        w_shift_next = tx_data;
                        w_get_next   = 1'b1;
                        w_place      = 1'b1;
                        w_bit        = tx_data[0];
                    end else begin
                        w_state_next = c_S_EOP_SE0;
                        w_idx_next   = 3'd0;
                    end
                end
            end
            c_S_EOP_SE0: begin
                if (w_boundary) begin
                    if (r_idx == 3'd0) begin
                        w_idx_next = 3'd1;
                    end else begin
                        w_state_next = c_S_EOP_J;
                        w_idx_next   = 3'd0;
                    end
                end
            end
            c_S_EOP_J: begin
                if (w_boundary) begin
                    w_state_next = c_S_IDLE;
                    w_div_next   = '0;
                    w_ones_next  = 3'd0;
                    w_level_next = 1'b1;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
                w_div_next   = '0;
                w_level_next = 1'b1;
            end
        endcase

        // NRZI: a zero toggles the line, a one holds it.
        if (w_place) begin
            w_level_next = w_bit ? w_level_next : ~w_level_next;
            w_ones_next  = w_bit ? (w_ones_next + 3'd1) : 3'd0;
        end
    end

    // Output decode from the next state so outputs are registered yet aligned.
    always_comb begin
        w_p_next    = 1'b1;
        w_n_next    = 1'b0;
        w_en_next   = 1'b0;
        w_busy_next = 1'b0;
        case (w_state_next)
            c_S_SYNC, c_S_PID, c_S_DATA: begin
                w_p_next    = w_level_next;
                w_n_next    = ~w_level_next;
                w_en_next   = 1'b1;
                w_busy_next = 1'b1;
            end
            c_S_EOP_SE0: begin
                w_p_next    = 1'b0;
                w_n_next    = 1'b0;
                w_en_next   = 1'b1;
                w_busy_next = 1'b1;
            end
            c_S_EOP_J: begin
                w_en_next   = 1'b1;
                w_busy_next = 1'b1;
            end
            default: begin
                w_p_next = 1'b1;
            end
        endcase
    end

    assign tx_data_get = r_get;
    assign tx_busy     = r_busy;
    assign usb_p_tx    = r_p;
    assign usb_n_tx    = r_n;
    assign usb_tx_en   = r_en;

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_fs_tx_serializer
// Brief    : Self-checking bench for usb_fs_tx_serializer against a list-based
//            packet line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_fs_tx_serializer;

    localparam int         BC      = 4;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic       clk_48mhz = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_data_avail;
    logic [7:0] tx_data;
    logic       tx_data_get;
    logic       tx_busy;
    logic       usb_p_tx;
    logic       usb_n_tx;
    logic       usb_tx_en;

    always #5 clk_48mhz = ~clk_48mhz;

    usb_fs_tx_serializer #(.BIT_CYCLES(BC)) dut (
        .clk_48mhz     (clk_48mhz),
        .reset         (reset),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_data_avail (tx_data_avail),
        .tx_data       (tx_data),
        .tx_data_get   (tx_data_get),
        .tx_busy       (tx_busy),
        .usb_p_tx      (usb_p_tx),
        .usb_n_tx      (usb_n_tx),
        .usb_tx_en     (usb_tx_en)
    );

    typedef struct {
        logic [3:0] pid;
        int         nb;
        logic [7:0] b [4];
        int         cycles;
        int         gets;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q[$];
    logic [1:0] exp_q[$];
    logic [1:0] rec[$];
    int         n_get;
    int         busy_bad;
    vec_t       vecs[6];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive_upstream();
        tx_data_avail = (q.size() != 0);
        tx_data       = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    // Expected line, one entry per clock: bits -> NRZI + stuffing -> EOP.
    function automatic void build_exp(input logic [3:0] pid, input logic [7:0] pay[$]);
        logic [7:0] bytes[$];
        logic [1:0] syms[$];
        logic       level;
        int         ones;
        bytes = pay;
        bytes.push_front({~pid, pid});
        bytes.push_front(8'h80);
        level = 1'b1;
        ones  = 0;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (bytes[i][b]) ones++;
                else begin
                    level = ~level;
                    ones  = 0;
                end
                syms.push_back(level ? SYM_J : SYM_K);
                if (ones == 6) begin
                    level = ~level;
                    ones  = 0;
                    syms.push_back(level ? SYM_J : SYM_K);
                end
            end
        end
        syms.push_back(SYM_SE0);
        syms.push_back(SYM_SE0);
        syms.push_back(SYM_J);
        exp_q.delete();
        foreach (syms[i]) for (int c = 0; c < BC; c++) exp_q.push_back(syms[i]);
    endfunction

    // Sends the packet whose payload is queued in q; optional spurious starts
    // and an optional reset at a given enabled-cycle index.
    task automatic run_packet(input logic [3:0] pid, input string name,
                              input bit spur, input int reset_at);
        logic [7:0] pay[$];
        int         cyc;
        int         bad;
        int         npay;
        pay  = q;
        npay = q.size();
        build_exp(pid, pay);
        rec.delete();
        n_get    = 0;
        busy_bad = 0;
        bad      = 0;
        cyc      = 0;
        drive_upstream();
        tx_pid   = pid;
        tx_start = 1'b1;
        @(negedge clk_48mhz);
        tx_start = 1'b0;
        tx_pid   = 4'($urandom);
        while (usb_tx_en && cyc < 4000) begin
            rec.push_back({usb_p_tx, usb_n_tx});
            if (!tx_busy) busy_bad++;
            if (tx_data_get) begin
                n_get++;
                if (q.size() != 0) void'(q.pop_front());
                drive_upstream();
            end
            tx_start = spur && (cyc == 3 || cyc == exp_q.size() - 3 || cyc == exp_q.size() - 1);
            if (cyc == reset_at) begin
                reset    = 1'b1;
                tx_start = 1'b1;
                @(negedge clk_48mhz);
                reset    = 1'b0;
                tx_start = 1'b0;
                check({name, " en"},   usb_tx_en,   0);
                check({name, " p"},    usb_p_tx,    1);
                check({name, " n"},    usb_n_tx,    0);
                check({name, " busy"}, tx_busy,     0);
                check({name, " get"},  tx_data_get, 0);
                q.delete();
                drive_upstream();
                @(negedge clk_48mhz);
                check({name, " start ignored under reset"}, usb_tx_en, 0);
                return;
            end
            @(negedge clk_48mhz);
            cyc++;
        end
        tx_start = 1'b0;
        check({name, " enabled cycles"}, rec.size(), exp_q.size());
        for (int i = 0; i < rec.size() && i < exp_q.size(); i++) begin
            if (rec[i] != exp_q[i]) bad++;
        end
        check({name, " wrong line cycles"}, bad, 0);
        check({name, " tx_data_get pulses"}, n_get, npay);
        check({name, " busy tracking"}, busy_bad + (tx_busy ? 1 : 0), 0);
    endtask

    initial begin
        vecs[0] = '{4'h2, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 76, 0};
        vecs[1] = '{4'h3, 2, '{8'hFF, 8'hFF, 8'h00, 8'h00}, 152, 2};
        vecs[2] = '{4'hB, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 76, 0};
        vecs[3] = '{4'h3, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 108, 1};
        vecs[4] = '{4'hF, 1, '{8'h3F, 8'h00, 8'h00, 8'h00}, 112, 1};
        vecs[5] = '{4'hE, 1, '{8'hFE, 8'h00, 8'h00, 8'h00}, 112, 1};

        reset         = 1'b1;
        tx_start      = 1'b0;
        tx_pid        = 4'h0;
        tx_data_avail = 1'b0;
        tx_data       = 8'h00;
        repeat (2) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        check("reset p",    usb_p_tx,    1);
        check("reset n",    usb_n_tx,    0);
        check("reset en",   usb_tx_en,   0);
        check("reset busy", tx_busy,     0);
        check("reset get",  tx_data_get, 0);
        reset = 1'b0;
        @(negedge clk_48mhz);

        for (int i = 0; i < 6; i++) begin
            q.delete();
            for (int j = 0; j < vecs[i].nb; j++) q.push_back(vecs[i].b[j]);
            run_packet(vecs[i].pid, $sformatf("vec%0d", i), 1'b0, -1);
            check($sformatf("vec%0d table cycles", i), rec.size(), vecs[i].cycles);
            check($sformatf("vec%0d table gets", i), n_get, vecs[i].gets);
            if (i == 0 && rec.size() == 76) begin
                check("ACK first bit K",      rec[0],  SYM_K);
                check("ACK bit14 K",          rec[56], SYM_K);
                check("ACK bit15 K",          rec[60], SYM_K);
                check("ACK SE0 start",        rec[64], SYM_SE0);
                check("ACK SE0 end",          rec[71], SYM_SE0);
                check("ACK EOP J start",      rec[72], SYM_J);
                check("ACK EOP J end",        rec[75], SYM_J);
            end
        end

        q = '{8'h11, 8'h22, 8'h33};
        run_packet(4'h3, "reset mid-data", 1'b0, 110);
        q = '{8'h5A, 8'hFF};
        run_packet(4'h3, "after reset", 1'b0, -1);

        q = '{8'hA5, 8'hFF};
        run_packet(4'hB, "spurious start", 1'b1, -1);

        for (int r = 0; r < 25; r++) begin
            int nb;
            q.delete();
            nb = $urandom_range(0, 5);
            for (int j = 0; j < nb; j++) begin
                q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            run_packet(4'($urandom), $sformatf("rand%0d", r), 1'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
